// File: rtl/ga_pkg.sv
// Shared GA datapath types: fitness width, selection mode and tournament FSM states.
package ga_pkg;

  localparam int FIT_W_DEFAULT = 27;

  typedef logic [FIT_W_DEFAULT-1:0] fitness_t;

  typedef enum logic {SEL_MIN = 1'b0, SEL_MAX = 1'b1} sel_mode_e;

  typedef enum logic {COLLECT = 1'b0, RESULT = 1'b1} tsel_state_e;

  function automatic sel_mode_e to_sel_mode(input logic maximize);
    return maximize ? SEL_MAX : SEL_MIN;
  endfunction

endpackage

// File: rtl/fitness_better.sv
// Better-or-equal fitness comparator; ties favour the candidate so later arrivals win.
module fitness_better
  import ga_pkg::*;
#(
  parameter int FIT_W = FIT_W_DEFAULT
) (
  input  logic [FIT_W-1:0] cand,
  input  logic [FIT_W-1:0] best,
  input  sel_mode_e        mode,
  output logic             take
);

  // unsigned magnitude compare in the direction chosen by mode
  always_comb begin
    take = 1'b0;
    if (mode == SEL_MAX) begin
      take = (cand >= best);
    end else begin
      take = (cand <= best);
    end
  end

endmodule

// File: rtl/tournament_selector.sv
// Streaming tournament selection: keeps a running best over TOUR_SIZE candidates
// and presents the winner on a valid/ready result port.
module tournament_selector
  import ga_pkg::*;
#(
  parameter int FIT_W     = FIT_W_DEFAULT,
  parameter int IDX_W     = 8,
  parameter int TOUR_SIZE = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush,
  input  logic                         maximize,
  input  logic                         cand_valid,
  output logic                         cand_ready,
  input  logic [IDX_W-1:0]             cand_idx,
  input  logic [FIT_W-1:0]             cand_fit,
  output logic                         win_valid,
  input  logic                         win_ready,
  output logic [IDX_W-1:0]             win_idx,
  output logic [FIT_W-1:0]             win_fit,
  output logic [$clog2(TOUR_SIZE)-1:0] win_pos
);

  localparam int CNT_W = $clog2(TOUR_SIZE);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TOUR_SIZE - 1);

  if (TOUR_SIZE < 2 || TOUR_SIZE > 64) begin : g_bad_tour_size
    $error("tournament_selector: TOUR_SIZE must be in 2..64");
  end

  tsel_state_e      state_r;
  sel_mode_e        mode_r;
  logic [CNT_W-1:0] count_r;
  logic [IDX_W-1:0] best_idx_r;
  logic [FIT_W-1:0] best_fit_r;
  logic [CNT_W-1:0] best_pos_r;
  logic             win_valid_r;
  logic             take_s;

  fitness_better #(.FIT_W(FIT_W)) u_better (
    .cand (cand_fit),
    .best (best_fit_r),
    .mode (mode_r),
    .take (take_s)
  );

  assign cand_ready = (state_r == COLLECT);
  assign win_valid  = win_valid_r;
  assign win_idx    = best_idx_r;
  assign win_fit    = best_fit_r;
  assign win_pos    = best_pos_r;

  // tournament FSM, candidate counter and running-best registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= COLLECT;
      mode_r      <= SEL_MIN;
      count_r     <= {CNT_W{1'b0}};
      best_idx_r  <= {IDX_W{1'b0}};
      best_fit_r  <= {FIT_W{1'b0}};
      best_pos_r  <= {CNT_W{1'b0}};
      win_valid_r <= 1'b0;
    end else if (flush) begin
      state_r     <= COLLECT;
      count_r     <= {CNT_W{1'b0}};
      win_valid_r <= 1'b0;
    end else begin
      case (state_r)
        COLLECT: begin
          if (cand_valid) begin
            // the first accept seeds the best and fixes the mode for this tournament
            if (count_r == {CNT_W{1'b0}}) begin
              best_idx_r <= cand_idx;
              best_fit_r <= cand_fit;
              best_pos_r <= {CNT_W{1'b0}};
              mode_r     <= to_sel_mode(maximize);
            end else if (take_s) begin
              best_idx_r <= cand_idx;
              best_fit_r <= cand_fit;
              best_pos_r <= count_r;
            end
            if (count_r == LAST_CNT) begin
              state_r     <= RESULT;
              count_r     <= {CNT_W{1'b0}};
              win_valid_r <= 1'b1;
            end else begin
              count_r <= count_r + CNT_W'(1);
            end
          end
        end
        RESULT: begin
          if (win_ready) begin
            state_r     <= COLLECT;
            win_valid_r <= 1'b0;
          end
        end
        default: begin
          state_r     <= COLLECT;
          count_r     <= {CNT_W{1'b0}};
          win_valid_r <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tournament_selector.sv
// Self-checking bench for tournament_selector (TOUR_SIZE=4) against a winner model
// that finds the extreme fitness, then the last position holding it.
module tb_tournament_selector;

  localparam int FW = 27;
  localparam int IW = 8;
  localparam int TS = 4;
  localparam logic [FW-1:0] FMAX = {FW{1'b1}};

  logic          clk;
  logic          rst_n;
  logic          flush;
  logic          maximize;
  logic          cand_valid;
  logic          cand_ready;
  logic [IW-1:0] cand_idx;
  logic [FW-1:0] cand_fit;
  logic          win_valid;
  logic          win_ready;
  logic [IW-1:0] win_idx;
  logic [FW-1:0] win_fit;
  logic [1:0]    win_pos;

  int checks;
  int failures;

  logic [FW-1:0] t_fit [TS];
  logic [IW-1:0] t_idx [TS];

  tournament_selector #(.FIT_W(FW), .IDX_W(IW), .TOUR_SIZE(TS)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .maximize   (maximize),
    .cand_valid (cand_valid),
    .cand_ready (cand_ready),
    .cand_idx   (cand_idx),
    .cand_fit   (cand_fit),
    .win_valid  (win_valid),
    .win_ready  (win_ready),
    .win_idx    (win_idx),
    .win_fit    (win_fit),
    .win_pos    (win_pos)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // winner: the most extreme fitness, and among equals the latest arrival
  task automatic model_win(input bit mx, output logic [IW-1:0] e_idx,
                           output logic [FW-1:0] e_fit, output logic [1:0] e_pos);
    logic [FW-1:0] ext;
    ext = t_fit[0];
    for (int i = 1; i < TS; i++)
      if (mx ? (t_fit[i] > ext) : (t_fit[i] < ext)) ext = t_fit[i];
    e_fit = ext;
    e_idx = t_idx[0];
    e_pos = 2'd0;
    for (int i = 0; i < TS; i++)
      if (t_fit[i] == ext) begin
        e_idx = t_idx[i];
        e_pos = 2'(i);
      end
  endtask

  // drive the t_* table as one tournament; optional idle gaps and mode toggling
  task automatic run_tour(input bit mx, input bit gaps, input bit toggle);
    for (int i = 0; i < TS; i++) begin
      if (gaps) begin
        cand_valid = 1'b0;
        repeat ($urandom_range(0, 2)) @(posedge clk);
        #1;
      end
      cand_valid = 1'b1;
      cand_idx   = t_idx[i];
      cand_fit   = t_fit[i];
      maximize   = (i == 0 || !toggle) ? mx : 1'($urandom_range(0, 1));
      checks++;
      if (cand_ready !== 1'b1) begin
        failures++;
        $display("FAIL cand_ready_collect: got %b want 1", cand_ready);
      end
      @(posedge clk);
      #1;
    end
    cand_valid = 1'b0;
    maximize   = $urandom_range(0, 1);
  endtask

  task automatic check_result(input string name, input bit mx);
    logic [IW-1:0] e_idx;
    logic [FW-1:0] e_fit;
    logic [1:0]    e_pos;
    model_win(mx, e_idx, e_fit, e_pos);
    checks++;
    if (win_valid !== 1'b1 || win_idx !== e_idx || win_fit !== e_fit || win_pos !== e_pos) begin
      failures++;
      $display("FAIL %s: got v=%b idx=%0d fit=%0d pos=%0d want v=1 idx=%0d fit=%0d pos=%0d",
               name, win_valid, win_idx, win_fit, win_pos, e_idx, e_fit, e_pos);
    end
  endtask

  task automatic consume();
    win_ready = 1'b1;
    @(posedge clk);
    #1;
    win_ready = 1'b0;
    checks++;
    if (win_valid !== 1'b0 || cand_ready !== 1'b1) begin
      failures++;
      $display("FAIL consume: got win_valid=%b cand_ready=%b want 0/1", win_valid, cand_ready);
    end
  endtask

  task automatic test_reset();
    checks++;
    if (cand_ready !== 1'b1 || win_valid !== 1'b0 || win_idx !== '0 || win_fit !== '0 || win_pos !== '0) begin
      failures++;
      $display("FAIL reset_values: got rdy=%b v=%b idx=%0d fit=%0d pos=%0d want 1 0 0 0 0",
               cand_ready, win_valid, win_idx, win_fit, win_pos);
    end
  endtask

  task automatic test_min();
    t_fit = '{27'd50, 27'd20, 27'd90, 27'd30};
    t_idx = '{8'd7, 8'd3, 8'd9, 8'd1};
    for (int i = 0; i < TS; i++) begin
      cand_valid = 1'b1;
      cand_idx   = t_idx[i];
      cand_fit   = t_fit[i];
      maximize   = 1'b0;
      checks++;
      if (win_valid !== 1'b0) begin
        failures++;
        $display("FAIL min_early_valid: got %b want 0 before accept %0d", win_valid, i);
      end
      @(posedge clk);
      #1;
    end
    cand_valid = 1'b0;
    check_result("min_basic", 1'b0);
    checks++;
    if (win_idx !== 8'd3 || win_fit !== 27'd20 || win_pos !== 2'd1) begin
      failures++;
      $display("FAIL min_const: got idx=%0d fit=%0d pos=%0d want 3 20 1", win_idx, win_fit, win_pos);
    end
    consume();
  endtask

  task automatic test_max_toggle();
    t_fit = '{27'd50, 27'd20, 27'd90, 27'd30};
    t_idx = '{8'd7, 8'd3, 8'd9, 8'd1};
    run_tour(1'b1, 1'b0, 1'b1);
    check_result("max_toggle", 1'b1);
    checks++;
    if (win_idx !== 8'd9 || win_fit !== 27'd90 || win_pos !== 2'd2) begin
      failures++;
      $display("FAIL max_const: got idx=%0d fit=%0d pos=%0d want 9 90 2", win_idx, win_fit, win_pos);
    end
    consume();
  endtask

  task automatic test_ties_extremes();
    t_fit = '{27'd10, 27'd10, 27'd10, 27'd10};
    t_idx = '{8'd0, 8'd1, 8'd2, 8'd3};
    run_tour(1'b0, 1'b0, 1'b0);
    check_result("ties_min", 1'b0);
    consume();
    for (int m = 0; m < 2; m++) begin
      t_fit = '{FMAX, 27'd0, FMAX, 27'd5};
      t_idx = '{8'd11, 8'd22, 8'd33, 8'd44};
      run_tour(m[0], 1'b0, 1'b0);
      check_result(m ? "extreme_max" : "extreme_min", m[0]);
      consume();
    end
  endtask

  task automatic test_backpressure();
    logic [IW-1:0] h_idx;
    logic [FW-1:0] h_fit;
    logic [1:0]    h_pos;
    for (int i = 0; i < TS; i++) begin
      t_fit[i] = $urandom_range(0, 1000);
      t_idx[i] = $urandom_range(0, 255);
    end
    run_tour(1'b1, 1'b1, 1'b0);
    check_result("bp_gaps", 1'b1);
    h_idx = win_idx;
    h_fit = win_fit;
    h_pos = win_pos;
    for (int c = 0; c < 5; c++) begin
      cand_valid = 1'b1;
      cand_fit   = 27'd0;
      @(posedge clk);
      #1;
      checks++;
      if (win_valid !== 1'b1 || cand_ready !== 1'b0 || win_idx !== h_idx || win_fit !== h_fit || win_pos !== h_pos) begin
        failures++;
        $display("FAIL bp_hold: cycle %0d got v=%b rdy=%b idx=%0d fit=%0d", c, win_valid, cand_ready, win_idx, win_fit);
      end
    end
    cand_valid = 1'b0;
    consume();
  endtask

  task automatic test_flush();
    cand_valid = 1'b1; cand_idx = 8'd100; cand_fit = 27'd5;  maximize = 1'b0;
    @(posedge clk); #1;
    cand_idx = 8'd101; cand_fit = 27'd6;
    @(posedge clk); #1;
    flush = 1'b1; cand_idx = 8'd102; cand_fit = 27'd0;
    @(posedge clk); #1;
    flush = 1'b0; cand_valid = 1'b0;
    t_fit = '{27'd40, 27'd41, 27'd42, 27'd43};
    t_idx = '{8'd50, 8'd51, 8'd52, 8'd53};
    run_tour(1'b0, 1'b0, 1'b0);
    check_result("flush_collect", 1'b0);
    checks++;
    if (win_fit !== 27'd40 || win_pos !== 2'd0) begin
      failures++;
      $display("FAIL flush_const: got fit=%0d pos=%0d want 40 0", win_fit, win_pos);
    end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    checks++;
    if (win_valid !== 1'b0 || cand_ready !== 1'b1) begin
      failures++;
      $display("FAIL flush_result: got v=%b rdy=%b want 0 1", win_valid, cand_ready);
    end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 3; i++) begin
      cand_valid = 1'b1; cand_idx = 8'(i + 60); cand_fit = 27'(i + 7); maximize = 1'b1;
      @(posedge clk); #1;
    end
    cand_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (cand_ready !== 1'b1 || win_valid !== 1'b0 || win_idx !== '0 || win_fit !== '0 || win_pos !== '0) begin
      failures++;
      $display("FAIL async_reset: got rdy=%b v=%b idx=%0d fit=%0d pos=%0d want 1 0 0 0 0",
               cand_ready, win_valid, win_idx, win_fit, win_pos);
    end
    #3;
    rst_n = 1'b1;
    @(posedge clk); #1;
    t_fit = '{27'd9, 27'd3, 27'd3, 27'd8};
    t_idx = '{8'd1, 8'd2, 8'd3, 8'd4};
    run_tour(1'b0, 1'b0, 1'b0);
    check_result("after_reset", 1'b0);
    consume();
  endtask

  task automatic test_random();
    bit mx;
    logic [IW-1:0] h_idx;
    logic [FW-1:0] h_fit;
    for (int n = 0; n < 25; n++) begin
      mx = 1'($urandom_range(0, 1));
      for (int i = 0; i < TS; i++) begin
        t_fit[i] = (n % 2 == 0) ? 27'($urandom_range(0, 7)) : 27'($urandom);
        t_idx[i] = 8'($urandom);
      end
      run_tour(mx, 1'b1, 1'b1);
      check_result("random", mx);
      h_idx = win_idx;
      h_fit = win_fit;
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
      checks++;
      if (win_valid !== 1'b1 || win_idx !== h_idx || win_fit !== h_fit) begin
        failures++;
        $display("FAIL random_hold: got v=%b idx=%0d fit=%0d", win_valid, win_idx, win_fit);
      end
      consume();
    end
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    rst_n      = 1'b0;
    flush      = 1'b0;
    maximize   = 1'b0;
    cand_valid = 1'b0;
    cand_idx   = '0;
    cand_fit   = '0;
    win_ready  = 1'b0;
    #12;
    test_reset();
    #10;
    rst_n = 1'b1;
    @(posedge clk); #1;
    test_reset();
    test_min();
    test_max_toggle();
    test_ties_extremes();
    test_backpressure();
    test_flush();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tournament_selector.md
# tournament_selector

- Parametrised, streaming tournament-selection unit for the GA datapath.
- Consumes `TOUR_SIZE` candidates (population index plus fitness) over a valid/ready stream and keeps a running best.
- Presents the winning index, its fitness and its position in the tournament on a result handshake.
- Sits between the random-index fetch stage and the crossover stage; supports minimisation or maximisation chosen per tournament.

## Interface
Parameters:
- `FIT_W`, 27: fitness width, unsigned.
- `IDX_W`, 8: population index width.
- `TOUR_SIZE`, 4: candidates per tournament; legal range 2..64; elaboration error outside this range.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `flush`  in  1  synchronous abort of the current tournament.
- `maximize`  in  1  0 = lower fitness wins, 1 = higher wins; sampled with the first candidate of each tournament.
- `cand_valid`  in  1  candidate present.
- `cand_ready`  out  1  block accepts a candidate.
- `cand_idx`  in  `IDX_W`  candidate population index.
- `cand_fit`  in  `FIT_W`  candidate fitness.
- `win_valid`  out  1  result present.
- `win_ready`  in  1  consumer takes the result.
- `win_idx`  out  `IDX_W`  winner index.
- `win_fit`  out  `FIT_W`  winner fitness.
- `win_pos`  out  `$clog2(TOUR_SIZE)`  arrival position of the winner within the tournament, 0-based.

## Operation
- States: COLLECT and RESULT. Reset state is COLLECT.
- In COLLECT: `cand_ready`=1, `win_valid`=0.
  - A candidate is accepted when `cand_valid && cand_ready`.
  - The first accept (count=0) loads best_idx, best_fit, best_pos=0 and latches `maximize` into mode_q.
  - Each later accept replaces the best when the candidate is better, or when it equals the best.
  - Better means `cand_fit < best_fit` if mode_q=0, or `cand_fit > best_fit` if mode_q=1.
  - Ties therefore go to the later candidate, the same tie rule as the two-input selector.
  - count increments on every accept.
  - On the accept with count = `TOUR_SIZE`-1, go to RESULT and clear count.
- In RESULT: `cand_ready`=0, `win_valid`=1.
  - `win_*` hold stable until `win_ready`.
  - On `win_valid && win_ready`, go to COLLECT.
- `flush` (highest priority):
  - Next state is COLLECT, count=0, `win_valid` deasserts.
  - Any candidate presented in the same cycle is dropped; any result is discarded.
- `maximize` changes mid-tournament are ignored until the next first accept.
- Arithmetic: plain unsigned magnitude compare at `FIT_W` bits. No saturation, no sign.
- count width is `$clog2(TOUR_SIZE)`. It never wraps past `TOUR_SIZE`-1.

## Timing
- Reset values: `cand_ready`=1 (combinational from state), `win_valid`=0, `win_idx`=0, `win_fit`=0, `win_pos`=0. Internal count=0, mode_q=0.
- `rst_n` assertion mid-tournament or mid-result clears everything asynchronously. Partial tournaments are lost.
- Latency: `win_valid` rises on the cycle after the `TOUR_SIZE`-th accept.
- Minimum period: `TOUR_SIZE`+1 cycles per tournament, including one result cycle with `cand_ready`=0.
- Ready/valid: `cand_ready` does not depend on `cand_valid`. `win_valid` does not depend on `win_ready`.
- Valid, once asserted, is held by the producer until accepted.
- All outputs except `cand_ready` are registered.

## Structure
- Shared package `ga_pkg`:
  - `FIT_W_DEFAULT`=27.
  - `fitness_t` typedef, `logic [FIT_W_DEFAULT-1:0]`.
  - `sel_mode_e` enum {SEL_MIN, SEL_MAX}.
  - `tsel_state_e` enum {COLLECT, RESULT}.
- One sub-module, `fitness_better`: combinational, parametrised on `FIT_W`.
  - Inputs: cand, best, mode.
  - Output: take = better-or-equal per the rule above.
  - It is reused by the elitism block.
- The top holds the FSM, count and best registers only.

## Test plan
- MIN, `TOUR_SIZE`=4: fitness 50, 20, 90, 30 at idx 7, 3, 9, 1, back-to-back. Expect idx=3, fit=20, pos=1; `win_valid` on the cycle after the 4th accept.
- MAX with the same stream. Expect idx=9, fit=90, pos=2. Toggling `maximize` during candidates 2–4 must not change the result.
- Ties: fitness 10, 10, 10, 10 at idx 0..3, MIN. Expect idx=3, pos=3. Extremes 0 and 2^27-1 must compare correctly in both modes.
- Backpressure:
  - `win_ready`=0 for 5 cycles: `win_*` stable and `cand_ready`=0 throughout.
  - Release `win_ready`: `cand_ready`=1 the next cycle.
  - Gaps on `cand_valid` must not affect the result.
- `flush` after 2 candidates, then 4 new candidates 40, 41, 42, 43, MIN. Expect fit=40, pos=0. `flush` during RESULT drops the result.
- `rst_n` low after 3 candidates. All outputs must read their reset values immediately (asynchronous). After release, a fresh 4-candidate tournament must complete correctly.
